mmcm_drp_reconfig: RTL and testbench

MMCM_DRP_RECONFIG -- requirements
Module: mmcm_drp_reconfig

---
 rtl/mmcm_drp_reconfig.sv | 160 ++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// ----------------------------------------------------------------------------
// mmcm_drp_reconfig : replays a ROM of {addr, mask, data} entries into an MMCM
// as DRP read-modify-write cycles while holding the MMCM in reset.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmcm_drp_reconfig #(
  parameter int N_ENTRIES    = 23,
  parameter int DRDY_TIMEOUT = 255
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        SSTEP,
  output logic        BUSY,
  output logic        ERROR,
  output logic [5:0]  ROM_ADDR,
  input  logic [38:0] ROM_DATA,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        RST_MMCM
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    ROM_WAIT  = 3'd2,
    DRP_RD    = 3'd3,
    WAIT_RD   = 3'd4,
    DRP_WR    = 3'd5,
    WAIT_WR   = 3'd6
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(N_ENTRIES - 1);
  localparam logic [15:0] TO_LAST  = 16'(DRDY_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  idx;
  logic [15:0] wait_cnt;
  logic [6:0]  daddr_q;
  logic [15:0] mask_q;
  logic [15:0] data_q;
  logic [15:0] di_q;
  logic        rst_mmcm_q;
  logic        error_q;
  logic        timed_out;

  // DRDY on the final allowed wait cycle wins over the timeout.
  assign timed_out = (wait_cnt == TO_LAST) && !DRDY;

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b1;
    DEN       = 1'b0;
    DWE       = 1'b0;
    DADDR     = daddr_q;
    case (state)
      WAIT_LOCK: if (LOCKED) state_nxt = IDLE;
      IDLE: begin
        BUSY = 1'b0;
        if (SSTEP) state_nxt = ROM_WAIT;
      end
      ROM_WAIT: state_nxt = DRP_RD;
      DRP_RD: begin
        DEN       = 1'b1;
        DADDR     = ROM_DATA[38:32];
        state_nxt = WAIT_RD;
      end
      WAIT_RD: begin
        if (DRDY)           state_nxt = DRP_WR;
        else if (timed_out) state_nxt = WAIT_LOCK;
      end
      DRP_WR: begin
        DEN       = 1'b1;
        DWE       = 1'b1;
        state_nxt = WAIT_WR;
      end
      WAIT_WR: begin
        if (DRDY)           state_nxt = (idx == LAST_IDX) ? WAIT_LOCK : ROM_WAIT;
        else if (timed_out) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      idx        <= 6'd0;
      wait_cnt   <= 16'd0;
      daddr_q    <= 7'd0;
      mask_q     <= 16'd0;
      data_q     <= 16'd0;
      di_q       <= 16'd0;
      rst_mmcm_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SSTEP) begin
            idx        <= 6'd0;
            rst_mmcm_q <= 1'b1;
            error_q    <= 1'b0;
          end
        end
        DRP_RD: begin
          daddr_q  <= ROM_DATA[38:32];
          mask_q   <= ROM_DATA[31:16];
          data_q   <= ROM_DATA[15:0];
          wait_cnt <= 16'd0;
        end
        WAIT_RD: begin
          // Mask bit set keeps the bit currently held in the MMCM register.
          if (DRDY) begin
            di_q <= (DO & mask_q) | (data_q & ~mask_q);
          end else if (timed_out) begin
            error_q    <= 1'b1;
            rst_mmcm_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DRP_WR: wait_cnt <= 16'd0;
        WAIT_WR: begin
          if (DRDY) begin
            if (idx == LAST_IDX) rst_mmcm_q <= 1'b0;
            else                 idx        <= idx + 6'd1;
          end else if (timed_out) begin
            error_q    <= 1'b1;
            rst_mmcm_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ROM_ADDR = idx;
  assign DI       = di_q;
  assign ERROR    = error_q;
  assign RST_MMCM = rst_mmcm_q;

endmodule

`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
// ----------------------------------------------------------------------------
// tb_mmcm_drp_reconfig : ROM + DRP slave model with a transaction scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmcm_drp_reconfig;
  localparam int N  = 23;
  localparam int TO = 16;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1;
  logic        SSTEP = 1'b0;
  logic        LOCKED = 1'b0;
  logic        BUSY, ERROR, DEN, DWE, RST_MMCM;
  logic [5:0]  ROM_ADDR;
  logic [38:0] ROM_DATA = '0;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;

  always #5 DCLK = ~DCLK;

  mmcm_drp_reconfig #(.N_ENTRIES(N), .DRDY_TIMEOUT(TO)) dut (
    .DCLK(DCLK), .RST(RST), .SSTEP(SSTEP), .BUSY(BUSY), .ERROR(ERROR),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .DADDR(DADDR), .DEN(DEN),
    .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED),
    .RST_MMCM(RST_MMCM)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] init_do;
    logic [15:0] exp_di;
  } vec_t;

  typedef struct {
    logic        we;
    logic [5:0]  idx;
    logic [6:0]  addr;
    logic [15:0] di;
  } txn_t;

  vec_t        vec [N];
  txn_t        sb [$];
  logic [38:0] rom [0:63];
  logic [15:0] mem [0:127];
  logic [15:0] ref_mem [0:127];

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          delay = 3;
  bit          withhold = 1'b0;
  int          spur_req = 0;
  int          spur_ack = 0;
  bit          pend = 1'b0;
  int          rem = 0;
  logic [6:0]  p_addr = '0;
  int          phase;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_run(input bit first);
    txn_t t;
    for (int i = 0; i < N; i++) begin
      t.we = 1'b0; t.idx = 6'(i); t.addr = vec[i].addr; t.di = '0;
      sb.push_back(t);
      t.we = 1'b1;
      t.di = first ? vec[i].exp_di
                   : (ref_mem[vec[i].addr] & vec[i].mask) | (vec[i].data & ~vec[i].mask);
      sb.push_back(t);
    end
  endfunction

  task automatic start_run(input bit first);
    n_rd = 0;
    n_wr = 0;
    push_run(first);
    SSTEP = 1'b1;
    @(negedge DCLK);
    SSTEP = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      @(negedge DCLK);
      n++;
    end
    chk(name, 32'(BUSY), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},     32'(BUSY),     32'd1);
    chk({tag, "_error"},    32'(ERROR),    32'd0);
    chk({tag, "_rom_addr"}, 32'(ROM_ADDR), 32'd0);
    chk({tag, "_daddr"},    32'(DADDR),    32'd0);
    chk({tag, "_di"},       32'(DI),       32'd0);
    chk({tag, "_den"},      32'(DEN),      32'd0);
    chk({tag, "_dwe"},      32'(DWE),      32'd0);
    chk({tag, "_rst_mmcm"}, 32'(RST_MMCM), 32'd0);
  endtask

  task automatic check_run_counts(input string tag);
    chk({tag, "_reads"},  32'(n_rd),      32'(N));
    chk({tag, "_writes"}, 32'(n_wr),      32'(N));
    chk({tag, "_sb"},     32'(sb.size()), 32'd0);
  endtask

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge DCLK) ROM_DATA <= rom[ROM_ADDR];

  // DRP slave plus scoreboard consumer.
  initial begin : drp_slave
    txn_t t;
    forever begin
      @(negedge DCLK);
      DRDY = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        DRDY = 1'b1;
      end
      if (DEN) begin
        chk("den_overlap", 32'(pend), 32'd0);
        chk("den_expected", 32'(sb.size() != 0), 32'd1);
        chk("rst_mmcm_during_drp", 32'(RST_MMCM), 32'd1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          chk("dwe", 32'(DWE), 32'(t.we));
          chk("daddr", 32'(DADDR), 32'(t.addr));
          chk("rom_addr", 32'(ROM_ADDR), 32'(t.idx));
          if (t.we) begin
            chk("di", 32'(DI), 32'(t.di));
            ref_mem[t.addr] = t.di;
          end
        end
        if (DWE) begin
          mem[DADDR] = DI;
          n_wr++;
        end else begin
          n_rd++;
        end
        if (!(withhold && !DWE)) begin
          pend   = 1'b1;
          rem    = delay;
          p_addr = DADDR;
        end
      end else if (pend) begin
        rem--;
        if (rem == 0) begin
          pend = 1'b0;
          DRDY = 1'b1;
          DO   = mem[p_addr];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    for (int a = 0; a < 128; a++) begin
      mem[a]     = '0;
      ref_mem[a] = '0;
    end
    for (int a = 0; a < 64; a++) rom[a] = '0;
    for (int i = 0; i < N; i++) begin
      vec[i].addr    = 7'(8 + i);
      vec[i].mask    = 16'(16'hFFFF << (i % 16));
      vec[i].data    = 16'(i * 4951 + 7);
      vec[i].init_do = 16'(16'hC3C3 ^ (i * 257));
      vec[i].exp_di  = (vec[i].init_do & vec[i].mask) | (vec[i].data & ~vec[i].mask);
    end
    vec[0] = '{7'h08, 16'hF000, 16'h0041, 16'hA5A5, 16'hA041};
    for (int i = 0; i < N; i++) begin
      rom[i]              = {vec[i].addr, vec[i].mask, vec[i].data};
      mem[vec[i].addr]     = vec[i].init_do;
      ref_mem[vec[i].addr] = vec[i].init_do;
    end

    // Reset state, then release into WAIT_LOCK -> IDLE.
    repeat (3) @(negedge DCLK);
    check_reset("reset");
    RST = 1'b0;
    LOCKED = 1'b1;
    repeat (2) @(negedge DCLK);
    chk("idle_after_lock", 32'(BUSY), 32'd0);

    // Reference run.
    start_run(1'b1);
    wait_idle("run1_done", 2000);
    check_run_counts("run1");
    chk("run1_rst_mmcm_low", 32'(RST_MMCM), 32'd0);
    chk("run1_error", 32'(ERROR), 32'd0);

    // SSTEP in DRP_RD, WAIT_WR and WAIT_LOCK must have no effect.
    LOCKED = 1'b0;
    start_run(1'b0);
    phase = 0;
    for (int n = 0; n < 3000 && phase < 4; n++) begin
      @(negedge DCLK);
      SSTEP = 1'b0;
      case (phase)
        0: if (DEN && !DWE && ROM_ADDR == 6'd3) begin SSTEP = 1'b1; phase = 1; end
        1: if (DEN && DWE && ROM_ADDR == 6'd5) phase = 2;
        2: begin SSTEP = 1'b1; phase = 3; end
        3: if (!RST_MMCM) begin SSTEP = 1'b1; phase = 4; end
        default: ;
      endcase
    end
    chk("glitch_phases", 32'(phase), 32'd4);
    @(negedge DCLK);
    SSTEP = 1'b0;
    repeat (4) @(negedge DCLK);
    chk("busy_in_wait_lock", 32'(BUSY), 32'd1);
    check_run_counts("run2");
    LOCKED = 1'b1;
    wait_idle("run2_idle", 10);

    // Withheld DRDY: abort after exactly TO wait cycles.
    withhold = 1'b1;
    start_run(1'b0);
    for (int n = 0; n < 20 && !DEN; n++) @(negedge DCLK);
    chk("timeout_read_den", 32'(DEN), 32'd1);
    repeat (TO) @(negedge DCLK);
    chk("error_before_timeout", 32'(ERROR), 32'd0);
    @(negedge DCLK);
    chk("error_at_timeout", 32'(ERROR), 32'd1);
    chk("rst_mmcm_after_timeout", 32'(RST_MMCM), 32'd0);
    sb.delete();
    withhold = 1'b0;
    repeat (20) @(negedge DCLK);
    chk("timeout_idle", 32'(BUSY), 32'd0);
    chk("error_sticky", 32'(ERROR), 32'd1);
    chk("timeout_no_write", 32'(n_wr), 32'd0);

    // Asynchronous reset during WAIT_RD of entry 5.
    start_run(1'b0);
    chk("error_cleared_by_sstep", 32'(ERROR), 32'd0);
    for (int n = 0; n < 500 && !(DEN && !DWE && ROM_ADDR == 6'd5); n++) @(negedge DCLK);
    chk("entry5_read", 32'(ROM_ADDR), 32'd5);
    @(negedge DCLK);
    #1 RST = 1'b1;
    #1 check_reset("async_rst");
    sb.delete();
    LOCKED = 1'b0;
    repeat (3) @(negedge DCLK);
    RST = 1'b0;
    LOCKED = 1'b1;
    repeat (2) @(negedge DCLK);
    chk("post_rst_idle", 32'(BUSY), 32'd0);

    // Spurious DRDY in IDLE, then DRDY exactly on the timeout boundary.
    spur_req++;
    repeat (4) @(negedge DCLK);
    chk("spurious_drdy_idle", 32'(BUSY), 32'd0);
    chk("spurious_drdy_rom_addr", 32'(ROM_ADDR), 32'd0);
    delay = TO;
    start_run(1'b0);
    wait_idle("boundary_done", 3000);
    check_run_counts("boundary");
    chk("boundary_error", 32'(ERROR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
